max_pool_2x2: RTL and testbench

Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of the 1×1 convolution stage. It consumes that stage's raster-order signed 16-bit pixel stream of an `image_size`×`image_size` feature map. It emits one pooled value per complete 2×2 block, so the output map is floor(`image_size`/2) square. A half-row line buffer holds the partial maxima of each even row. Input may stall freely, and no back-pressure is provided.

---
 rtl/max_pool_2x2.sv | 147 ++++++++++++++
 tb/tb_max_pool_2x2.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 max-pool over a raster-order signed pixel stream.
// Optional fused ReLU on the pooled result when MAX_POOL_RELU_EN is defined.
module max_pool_2x2 #(
  parameter int DATA_W   = 16,
  parameter int MAX_SIZE = 256
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [8:0]               image_size,
  input  logic                     pi_data_valid,
  input  logic signed [DATA_W-1:0] pi_data,
  output logic                     po_data_valid,
  output logic signed [DATA_W-1:0] po_data,
  output logic                     frame_valid
);

  localparam int DEPTH = MAX_SIZE / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a sample is taken on every rising edge where pi_data_valid is
  // high and sys_rst is low; po_data_valid/frame_valid are single-cycle strobes
  // with no ready, so the consumer must always accept.

  logic [8:0]               cnt_col_q, cnt_col_d;
  logic [8:0]               cnt_row_q, cnt_row_d;
  logic signed [DATA_W-1:0] pair_lo_q, pair_lo_d;

  logic                     s1_out_q, s1_out_d;
  logic                     s1_frame_q, s1_frame_d;
  logic signed [DATA_W-1:0] s1_pair_q, s1_pair_d;
  logic [AW-1:0]            s1_idx_q, s1_idx_d;

  logic                     s2_out_q, s2_out_d;
  logic                     s2_frame_q, s2_frame_d;
  logic signed [DATA_W-1:0] s2_pair_q, s2_pair_d;
  logic signed [DATA_W-1:0] s2_lb_q;

  logic                     po_valid_q, po_valid_d;
  logic signed [DATA_W-1:0] po_data_q, po_data_d;
  logic                     frame_q, frame_d;

  logic signed [DATA_W-1:0] line_buf [DEPTH];

  logic                     last_col, last_row;
  logic                     col_odd, row_odd;
  logic                     do_pair, do_lo, lb_wr;
  logic signed [DATA_W-1:0] pair_max;
  logic signed [DATA_W-1:0] pooled, pool_out;
  logic [8:0]               col_half;
  logic [AW-1:0]            cur_idx;

  assign last_col = (cnt_col_q == image_size - 9'd1);
  assign last_row = (cnt_row_q == image_size - 9'd1);
  assign col_odd  = cnt_col_q[0];
  assign row_odd  = cnt_row_q[0];
  assign col_half = cnt_col_q >> 1;
  assign cur_idx  = col_half[AW-1:0];
  assign pair_max = (pi_data > pair_lo_q) ? pi_data : pair_lo_q;

  // An odd column always has an even partner; the unpaired last column of an
  // odd-sized map is even and is simply never latched into pair_lo.
  assign do_lo   = pi_data_valid && !col_odd && !last_col;
  assign do_pair = pi_data_valid && col_odd;
  assign lb_wr   = do_pair && !row_odd && !last_row && !sys_rst;

  always_comb begin
    cnt_col_d = cnt_col_q;
    cnt_row_d = cnt_row_q;
    if (pi_data_valid) begin
      if (last_col) begin
        cnt_col_d = '0;
        cnt_row_d = last_row ? 9'd0 : cnt_row_q + 9'd1;
      end else begin
        cnt_col_d = cnt_col_q + 9'd1;
      end
    end
  end

  always_comb begin
    pair_lo_d  = do_lo ? pi_data : pair_lo_q;
    s1_out_d   = do_pair && row_odd;
    s1_frame_d = pi_data_valid && last_col && last_row;
    s1_pair_d  = do_pair ? pair_max : s1_pair_q;
    s1_idx_d   = do_pair ? cur_idx : s1_idx_q;
    s2_out_d   = s1_out_q;
    s2_frame_d = s1_frame_q;
    s2_pair_d  = s1_pair_q;
  end

  always_comb begin
    pooled = (s2_lb_q > s2_pair_q) ? s2_lb_q : s2_pair_q;
`ifdef MAX_POOL_RELU_EN
    pool_out = pooled[DATA_W-1] ? '0 : pooled;
`else
    pool_out = pooled;
`endif
    po_valid_d = s2_out_q;
    po_data_d  = s2_out_q ? pool_out : po_data_q;
    frame_d    = s2_frame_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_col_q  <= '0;
      cnt_row_q  <= '0;
      pair_lo_q  <= '0;
      s1_out_q   <= 1'b0;
      s1_frame_q <= 1'b0;
      s1_pair_q  <= '0;
      s1_idx_q   <= '0;
      s2_out_q   <= 1'b0;
      s2_frame_q <= 1'b0;
      s2_pair_q  <= '0;
      po_valid_q <= 1'b0;
      po_data_q  <= '0;
      frame_q    <= 1'b0;
    end else begin
      cnt_col_q  <= cnt_col_d;
      cnt_row_q  <= cnt_row_d;
      pair_lo_q  <= pair_lo_d;
      s1_out_q   <= s1_out_d;
      s1_frame_q <= s1_frame_d;
      s1_pair_q  <= s1_pair_d;
      s1_idx_q   <= s1_idx_d;
      s2_out_q   <= s2_out_d;
      s2_frame_q <= s2_frame_d;
      s2_pair_q  <= s2_pair_d;
      po_valid_q <= po_valid_d;
      po_data_q  <= po_data_d;
      frame_q    <= frame_d;
    end
  end

  // Line buffer holds no reset: every entry is rewritten on an even row
  // before the following odd row reads it.
  always_ff @(posedge sys_clk) begin
    if (lb_wr) begin
      line_buf[cur_idx] <= pair_max;
    end
    s2_lb_q <= line_buf[s1_idx_q];
  end

  assign po_data_valid = po_valid_q;
  assign po_data       = po_data_q;
  assign frame_valid   = frame_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Randomized scoreboard bench for max_pool_2x2: a block-level reference model
// predicts pooled values, their due cycle and frame_valid pulses.
module tb_max_pool_2x2;

  logic               clk;
  logic               sys_rst;
  logic [8:0]         image_size;
  logic               pi_data_valid;
  logic signed [15:0] pi_data;
  logic               po_data_valid;
  logic signed [15:0] po_data;
  logic               frame_valid;

  max_pool_2x2 #(.DATA_W(16), .MAX_SIZE(256)) dut (
    .sys_clk       (clk),
    .sys_rst       (sys_rst),
    .image_size    (image_size),
    .pi_data_valid (pi_data_valid),
    .pi_data       (pi_data),
    .po_data_valid (po_data_valid),
    .po_data       (po_data),
    .frame_valid   (frame_valid)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // scoreboard state
  logic [15:0]        exp_q[$];
  int                 due_q[$];
  int                 fv_q[$];
  logic signed [15:0] last_exp = '0;
  bit                 mon_en = 1'b0;

  // reference model: whole frame kept as a picture, blocks pooled from it
  int m_size = 4;
  int m_row  = 0;
  int m_col  = 0;
  int m_pix [0:31][0:31];

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_accept(input int v);
    int r, c, m;
    r = m_row;
    c = m_col;
    m_pix[r][c] = v;
    if ((r % 2 == 1) && (c % 2 == 1) && (r / 2 < m_size / 2) && (c / 2 < m_size / 2)) begin
      m = max2(max2(m_pix[r-1][c-1], m_pix[r-1][c]), max2(m_pix[r][c-1], m_pix[r][c]));
`ifdef MAX_POOL_RELU_EN
      if (m < 0) m = 0;
`endif
      exp_q.push_back(16'(m));
      due_q.push_back(cyc + 3);
    end
    if (r == m_size - 1 && c == m_size - 1) fv_q.push_back(cyc + 3);
    if (c == m_size - 1) begin
      m_col = 0;
      m_row = (r == m_size - 1) ? 0 : r + 1;
    end else begin
      m_col = c + 1;
    end
  endtask

  // driver tasks: all start and end just after a falling edge
  task automatic idle_cycle();
    pi_data_valid = 1'b0;
    pi_data       = 16'($urandom);
    @(negedge clk); #1;
  endtask

  task automatic drive_px(input int v, input int max_gap);
    int g;
    g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    repeat (g) idle_cycle();
    pi_data_valid = 1'b1;
    pi_data       = 16'(v);
    model_accept(v);
    @(negedge clk); #1;
    pi_data_valid = 1'b0;
  endtask

  // kind 0: ramp+offset, 1: 10*row+col, 2: random full-range signed
  task automatic send_frame(input int size, input int kind, input int offset, input int max_gap);
    int v;
    image_size = 9'(size);
    m_size     = size;
    for (int i = 0; i < size * size; i++) begin
      case (kind)
        0:       v = offset + i;
        1:       v = 10 * (i / size) + (i % size);
        default: v = $signed(16'($urandom));
      endcase
      drive_px(v, max_gap);
    end
  endtask

  task automatic do_reset(input bit with_valid);
    sys_rst       = 1'b1;
    pi_data_valid = with_valid;
    pi_data       = 16'sd1234;
    exp_q.delete();
    due_q.delete();
    fv_q.delete();
    last_exp = '0;
    m_row    = 0;
    m_col    = 0;
    @(negedge clk); #1;
    sys_rst       = 1'b0;
    pi_data_valid = 1'b0;
  endtask

  // monitor: pops and compares whenever the DUT presents output
  always @(negedge clk) begin
    if (mon_en) begin
      while (due_q.size() > 0 && due_q[0] < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_output cyc=%0d expected value %0d due at %0d", cyc,
                 $signed(exp_q[0]), due_q[0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      checks++;
      if (po_data_valid) begin
        if (due_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output cyc=%0d got %0d, expected none", cyc, po_data);
        end else begin
          logic signed [15:0] ev;
          int                 ed;
          ev = exp_q.pop_front();
          ed = due_q.pop_front();
          if (po_data !== ev || ed != cyc) begin
            failures++;
            $display("FAIL pooled_value cyc=%0d got %0d, expected %0d at cyc %0d", cyc,
                     po_data, ev, ed);
          end
          last_exp = ev;
        end
      end else if (po_data !== last_exp) begin
        failures++;
        $display("FAIL po_data_hold cyc=%0d got %0d, expected %0d", cyc, po_data, last_exp);
      end
      while (fv_q.size() > 0 && fv_q[0] < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_frame_valid cyc=%0d due at %0d", cyc, fv_q[0]);
        void'(fv_q.pop_front());
      end
      checks++;
      if (frame_valid) begin
        if (fv_q.size() == 0 || fv_q[0] != cyc) begin
          failures++;
          $display("FAIL frame_valid cyc=%0d got 1, expected 0", cyc);
        end else begin
          void'(fv_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst       = 1'b1;
    image_size    = 9'd4;
    pi_data_valid = 1'b0;
    pi_data       = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (po_data_valid !== 1'b0 || po_data !== 16'sd0 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got valid=%b data=%0d fv=%b, expected 0 0 0",
               po_data_valid, po_data, frame_valid);
    end
    #1;
    sys_rst = 1'b0;
    mon_en  = 1'b1;
    idle_cycle();

    // 4x4 ramp, continuous
    send_frame(4, 0, 0, 0);
    repeat (4) idle_cycle();
    // 4x4 ramp with random stalls
    send_frame(4, 0, 0, 3);
    repeat (4) idle_cycle();
    // negative 2x2
    image_size = 9'd2;
    m_size     = 2;
    drive_px(-100, 0);
    drive_px(-3, 1);
    drive_px(-50, 0);
    drive_px(-7, 2);
    repeat (4) idle_cycle();
    // 5x5 odd size, continuous then stalled
    send_frame(5, 1, 0, 0);
    send_frame(5, 1, 0, 2);
    repeat (4) idle_cycle();
    // reset mid-frame after sample 6, with a sample offered during reset
    image_size = 9'd4;
    m_size     = 4;
    for (int i = 0; i <= 6; i++) drive_px(i, 0);
    do_reset(1'b1);
    send_frame(4, 0, 0, 0);
    // back-to-back frames, second offset by 100
    send_frame(4, 0, 0, 0);
    send_frame(4, 0, 100, 0);
    repeat (4) idle_cycle();
    // random sizes, random data, random stalls
    for (int f = 0; f < 12; f++) begin
      send_frame($urandom_range(9, 2), 2, 0, (f % 3));
    end
    repeat (3) idle_cycle();
    // mid-frame reset at a random point of a random frame
    image_size = 9'd6;
    m_size     = 6;
    for (int i = 0; i < $urandom_range(30, 8); i++) drive_px($signed(16'($urandom)), 1);
    do_reset(1'b0);
    send_frame(6, 2, 0, 1);
    repeat (8) idle_cycle();

    checks++;
    if (exp_q.size() != 0 || fv_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending outputs=%0d frames=%0d, expected 0 0", exp_q.size(),
               fv_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
